// File: rtl/fetch_stage_pkg.sv
// Shared definitions for the instruction fetch stage: FSM state encoding and
// the bubble instruction word.
package fetch_stage_pkg;

  typedef enum logic {
    RUN    = 1'b0,
    HALTED = 1'b1
  } fetch_state_e;

  // sll $0,$0,0 encodes as all zeros, so a bubble is architecturally a nop
  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  localparam logic [31:0] PC_STEP = 32'd4;

endpackage

// File: rtl/fetch_stage_if_id_reg.sv
// IF/ID pipeline register. Bubble insertion outranks hold, which outranks a
// normal load of the fetched instruction.
module if_id_reg
  import fetch_stage_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        hold,
  input  logic        bubble,
  input  logic [31:0] instr_in,
  input  logic [31:0] pc4_in,
  output logic [31:0] instr,
  output logic [31:0] pc4,
  output logic        valid
);

  logic [31:0] instr_d, instr_q;
  logic [31:0] pc4_d, pc4_q;
  logic        valid_d, valid_q;

  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (bubble) begin
      instr_d = NOP_INSTR;
      pc4_d   = 32'h0000_0000;
      valid_d = 1'b0;
    end else if (!hold) begin
      instr_d = instr_in;
      pc4_d   = pc4_in;
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      instr_q <= NOP_INSTR;
      pc4_q   <= 32'h0000_0000;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc4_q   <= pc4_d;
      valid_q <= valid_d;
    end
  end

  assign instr = instr_q;
  assign pc4   = pc4_q;
  assign valid = valid_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage: PC register, RUN/HALTED control FSM, fetch counter
// and the IF/ID register feeding the decoder.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          IMEM_AW  = 10
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               flush,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc,
  input  logic               halt,
  input  logic               resume,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [31:0]        imem_data,
  output logic [31:0]        if_id_instr,
  output logic [31:0]        if_id_pc4,
  output logic               if_id_valid,
  output logic [5:0]         op,
  output logic [5:0]         func,
  output logic               halted,
  output logic [31:0]        fetch_count
);

  fetch_state_e state_d, state_q;
  logic [31:0]  pc_d, pc_q;
  logic [31:0]  fetch_count_d, fetch_count_q;
  logic [31:0]  pc_plus4;
  logic         ifid_hold;
  logic         ifid_bubble;

  assign pc_plus4 = pc_q + PC_STEP;

  // Priority in RUN: halt > redirect > stall > flush > normal fetch
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    fetch_count_d = fetch_count_q;
    ifid_hold     = 1'b0;
    ifid_bubble   = 1'b0;
    if (state_q == HALTED) begin
      ifid_bubble = 1'b1;
      if (resume && !halt) begin
        state_d = RUN;
      end
    end else begin
      if (halt) begin
        state_d     = HALTED;
        ifid_bubble = 1'b1;
      end else if (redirect) begin
        pc_d        = redirect_pc;
        ifid_bubble = 1'b1;
      end else if (stall) begin
        ifid_hold = 1'b1;
      end else if (flush) begin
        pc_d        = pc_plus4;
        ifid_bubble = 1'b1;
      end else begin
        pc_d          = pc_plus4;
        fetch_count_d = fetch_count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= RUN;
      pc_q          <= RESET_PC;
      fetch_count_q <= 32'h0000_0000;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  if_id_reg u_if_id_reg (
    .clk      (clk),
    .rst      (rst),
    .hold     (ifid_hold),
    .bubble   (ifid_bubble),
    .instr_in (imem_data),
    .pc4_in   (pc_plus4),
    .instr    (if_id_instr),
    .pc4      (if_id_pc4),
    .valid    (if_id_valid)
  );

  // Low two PC bits select a byte within the word and never reach the ROM
  assign imem_addr   = pc_q[IMEM_AW+1:2];
  assign op          = if_id_instr[31:26];
  assign func        = if_id_instr[5:0];
  assign halted      = (state_q == HALTED);
  assign fetch_count = fetch_count_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed testbench for fetch_stage with a bench-owned ROM whose word at
// address A is 32'hC000_0000 | A.
module tb_fetch_stage;

  localparam int IMEM_AW = 10;

  logic               clk;
  logic               rst;
  logic               stall;
  logic               flush;
  logic               redirect;
  logic [31:0]        redirect_pc;
  logic               halt;
  logic               resume;
  logic [IMEM_AW-1:0] imem_addr;
  logic [31:0]        imem_data;
  logic [31:0]        if_id_instr;
  logic [31:0]        if_id_pc4;
  logic               if_id_valid;
  logic [5:0]         op;
  logic [5:0]         func;
  logic               halted;
  logic [31:0]        fetch_count;

  int checks;
  int errors;

  fetch_stage #(
    .RESET_PC (32'h0000_0000),
    .IMEM_AW  (IMEM_AW)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .flush       (flush),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .halt        (halt),
    .resume      (resume),
    .imem_addr   (imem_addr),
    .imem_data   (imem_data),
    .if_id_instr (if_id_instr),
    .if_id_pc4   (if_id_pc4),
    .if_id_valid (if_id_valid),
    .op          (op),
    .func        (func),
    .halted      (halted),
    .fetch_count (fetch_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Combinational instruction ROM model
  assign imem_data = 32'hC000_0000 | {22'b0, imem_addr};

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h, expected %h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of control inputs, then sample 1 time unit after the edge
  task automatic applyStimulus(input logic st, input logic fl, input logic rd,
                               input logic [31:0] rpc, input logic hl,
                               input logic rs);
    stall       = st;
    flush       = fl;
    redirect    = rd;
    redirect_pc = rpc;
    halt        = hl;
    resume      = rs;
    @(posedge clk);
    #1;
  endtask

  task automatic checkIfId(input string tag, input logic [31:0] instr,
                           input logic [31:0] pc4, input logic valid,
                           input logic [31:0] addr, input logic [31:0] cnt);
    checkOutput({tag, ".instr"}, if_id_instr, instr);
    checkOutput({tag, ".pc4"}, if_id_pc4, pc4);
    checkOutput({tag, ".valid"}, {31'b0, if_id_valid}, {31'b0, valid});
    checkOutput({tag, ".addr"}, {22'b0, imem_addr}, addr);
    checkOutput({tag, ".count"}, fetch_count, cnt);
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    rst         = 1'b1;
    stall       = 1'b0;
    flush       = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    halt        = 1'b0;
    resume      = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    checkIfId("reset", 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    checkOutput("reset.halted", {31'b0, halted}, 32'h0);
    rst = 1'b0;

    // Sequential fetch from RESET_PC
    applyStimulus(0, 0, 0, 32'h0, 0, 0);
    checkIfId("fetch0", 32'hC000_0000, 32'd4, 1'b1, 32'd1, 32'd1);
    applyStimulus(0, 0, 0, 32'h0, 0, 0);
    checkIfId("fetch1", 32'hC000_0001, 32'd8, 1'b1, 32'd2, 32'd2);
    checkOutput("fetch1.op", {26'b0, op}, 32'h30);
    checkOutput("fetch1.func", {26'b0, func}, 32'h01);

    // Two stall cycles at pc=8
    applyStimulus(1, 0, 0, 32'h0, 0, 0);
    checkIfId("stall0", 32'hC000_0001, 32'd8, 1'b1, 32'd2, 32'd2);
    applyStimulus(1, 0, 0, 32'h0, 0, 0);
    checkIfId("stall1", 32'hC000_0001, 32'd8, 1'b1, 32'd2, 32'd2);
    applyStimulus(0, 0, 0, 32'h0, 0, 0);
    checkIfId("fetch2", 32'hC000_0002, 32'd12, 1'b1, 32'd3, 32'd3);

    // Redirect wins over a simultaneous stall and flush
    applyStimulus(1, 1, 1, 32'h40, 0, 0);
    checkIfId("redir", 32'h0, 32'h0, 1'b0, 32'h10, 32'd3);
    applyStimulus(0, 0, 0, 32'h0, 0, 0);
    checkIfId("redir.tgt", 32'hC000_0010, 32'h44, 1'b1, 32'h11, 32'd4);

    // Flush still advances the PC
    applyStimulus(0, 1, 0, 32'h0, 0, 0);
    checkIfId("flush", 32'h0, 32'h0, 1'b0, 32'h12, 32'd4);

    // Misaligned redirect target: low bits ignored for addressing only
    applyStimulus(0, 0, 1, 32'h83, 0, 0);
    checkIfId("misal", 32'h0, 32'h0, 1'b0, 32'h20, 32'd4);
    applyStimulus(0, 0, 0, 32'h0, 0, 0);
    checkIfId("misal.tgt", 32'hC000_0020, 32'h87, 1'b1, 32'h21, 32'd5);

    // Halt beats redirect, then HALTED ignores redirect/stall/flush
    applyStimulus(0, 0, 1, 32'h100, 1, 0);
    checkIfId("halt", 32'h0, 32'h0, 1'b0, 32'h21, 32'd5);
    checkOutput("halt.halted", {31'b0, halted}, 32'h1);
    applyStimulus(1, 1, 1, 32'h200, 0, 0);
    checkIfId("halted", 32'h0, 32'h0, 1'b0, 32'h21, 32'd5);
    checkOutput("halted.halted", {31'b0, halted}, 32'h1);
    applyStimulus(0, 0, 0, 32'h0, 1, 1);
    checkOutput("resume.halt_wins", {31'b0, halted}, 32'h1);
    applyStimulus(0, 0, 0, 32'h0, 0, 1);
    checkIfId("resume", 32'h0, 32'h0, 1'b0, 32'h21, 32'd5);
    checkOutput("resume.halted", {31'b0, halted}, 32'h0);
    applyStimulus(0, 0, 0, 32'h0, 0, 0);
    checkIfId("resume.fetch", 32'hC000_0021, 32'h8B, 1'b1, 32'h22, 32'd6);

    // PC wrap at the top of the address space
    applyStimulus(0, 0, 1, 32'hFFFF_FFFC, 0, 0);
    checkIfId("wrap.redir", 32'h0, 32'h0, 1'b0, 32'h3FF, 32'd6);
    applyStimulus(0, 0, 0, 32'h0, 0, 0);
    checkIfId("wrap", 32'hC000_03FF, 32'h0, 1'b1, 32'h0, 32'd7);
    applyStimulus(0, 0, 0, 32'h0, 0, 0);
    checkIfId("wrap.next", 32'hC000_0000, 32'h4, 1'b1, 32'h1, 32'd8);

    // Asynchronous reset while HALTED, between clock edges
    applyStimulus(0, 0, 0, 32'h0, 1, 0);
    checkOutput("halt2.halted", {31'b0, halted}, 32'h1);
    halt = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    checkIfId("async_rst", 32'h0, 32'h0, 1'b0, 32'h0, 32'h0);
    checkOutput("async_rst.halted", {31'b0, halted}, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 0, 0, 32'h0, 0, 0);
    checkIfId("post_rst", 32'hC000_0000, 32'd4, 1'b1, 32'd1, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
